// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory loader: state encoding, memory geometry
// and the word-index to byte-address mapping used by the write port.
package loader_pkg;

    localparam int IMEM_DEPTH = 200;
    localparam int WORD_BYTES = 4;
    localparam int LANE_W     = $clog2(WORD_BYTES);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_ERR   = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Byte address of a word slot; the fetch side reads with Address[31:2].
    function automatic logic [31:0] word_byte_addr(input logic [31:0] word_idx);
        return {word_idx[29:0], 2'b00};
    endfunction

endpackage

// File: rtl/byte_packer.sv
// Byte-to-word assembler: lane counter plus holding register for lanes 0..2, little-endian.
// word_vld_o is combinational with the 4th accepted byte; no backpressure of its own (caller gates byte_vld_i).
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        byte_vld_i,
    input  logic [7:0]  byte_dat_i,
    output logic        word_vld_o,
    output logic [31:0] word_dat_o
);

    logic [LANE_W-1:0] lane_q, lane_d;
    logic [23:0]       asm_q, asm_d;

    always_comb begin
        lane_d = lane_q;
        asm_d  = asm_q;
        if (clr_i) begin
            lane_d = '0;
        end else if (byte_vld_i) begin
            lane_d = lane_q + LANE_W'(1);
            case (lane_q)
                2'd0:    asm_d[7:0]   = byte_dat_i;
                2'd1:    asm_d[15:8]  = byte_dat_i;
                2'd2:    asm_d[23:16] = byte_dat_i;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            lane_q <= '0;
            asm_q  <= '0;
        end else begin
            lane_q <= lane_d;
            asm_q  <= asm_d;
        end
    end

    // The top lane is never stored: it completes the word on the same cycle.
    assign word_vld_o = byte_vld_i && !clr_i && (lane_q == LANE_W'(WORD_BYTES - 1));
    assign word_dat_o = {byte_dat_i, asm_q};

endmodule

// File: rtl/inst_mem_loader.sv
// Streams program bytes into instruction memory as word writes while freezing fetch; LOADER_CHECKSUM_EN adds an XOR trailer check.
// Each write strobes the cycle after its 4th byte; byte_ready is a pure function of state (high in LOAD/CHECK).
module inst_mem_loader
    import loader_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len_words,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    output logic             wr_en,
    output logic [31:0]      wr_addr,
    output logic [31:0]      wr_data,
    output logic             cpu_hold,
    output logic             done,
    output logic             error
);

    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] word_idx_q, word_idx_d;
    logic             error_q, error_d;
    logic             wr_en_q;
    logic [31:0]      wr_addr_q, wr_data_q;

    logic             byte_acc;
    logic             pack_acc;
    logic             pack_clr;
    logic             word_vld;
    logic [31:0]      word_dat;
    logic             start_ok;
    logic             len_ok;
    logic             last_word;

    assign byte_ready = (state_q == ST_LOAD) || (state_q == ST_CHECK);
    assign cpu_hold   = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign error      = error_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;

    assign byte_acc  = byte_valid && byte_ready;
    assign pack_acc  = byte_acc && (state_q == ST_LOAD);
    assign pack_clr  = (state_q != ST_LOAD);
    // ERR behaves like IDLE for new requests; it is only reachable with the checksum build.
    assign start_ok  = start && ((state_q == ST_IDLE) || (state_q == ST_ERR));
    assign len_ok    = (len_words != '0) && (len_words <= DEPTH_L);
    assign last_word = (word_idx_q == len_q - LEN_W'(1));

    byte_packer u_packer (
        .clk_i      (clk),
        .rst_i      (rst),
        .clr_i      (pack_clr),
        .byte_vld_i (pack_acc),
        .byte_dat_i (byte_data),
        .word_vld_o (word_vld),
        .word_dat_o (word_dat)
    );

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (start_ok && len_ok) begin
            csum_d = '0;
        end else if (pack_acc) begin
            csum_d = csum_q ^ byte_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_idx_d = word_idx_q;
        error_d    = error_q;
        if (start_ok) begin
            if (len_ok) begin
                state_d    = ST_LOAD;
                len_d      = len_words;
                word_idx_d = '0;
                error_d    = 1'b0;
            end else begin
                error_d = 1'b1;
            end
        end
        case (state_q)
            ST_LOAD: begin
                if (word_vld) begin
                    if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = ST_CHECK;
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        word_idx_d = word_idx_q + LEN_W'(1);
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (byte_acc) begin
                    if (byte_data == csum_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ERR;
                        error_d = 1'b1;
                    end
                end
            end
`endif
            ST_DONE: state_d = ST_IDLE;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            word_idx_q <= '0;
            error_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_idx_q <= word_idx_d;
            error_q    <= error_d;
            wr_en_q    <= word_vld;
            if (word_vld) begin
                wr_addr_q <= word_byte_addr(32'(word_idx_q));
                wr_data_q <= word_dat;
            end
        end
    end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Randomized scoreboard bench for inst_mem_loader; expected writes come from a byte-list model.
module tb_inst_mem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  len_words = 8'd0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'd0;
    logic        byte_ready, wr_en, cpu_hold, done, error;
    logic [31:0] wr_addr, wr_data;

    always #5 clk = ~clk;

    inst_mem_loader #(.DEPTH(200), .LEN_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len_words  (len_words),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    int          checks = 0;
    int          errors = 0;
    int          wr_cnt = 0;
    int          done_cnt = 0;
    logic [31:0] last_addr = 32'd0;
    logic        prev_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (rst) begin
            if (wr_en) begin
                wr_cnt++;
                last_addr = wr_addr;
                if (exp_q.size() == 0) begin
                    chk("unexpected_wr", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("wr_addr", wr_addr, mon_e.addr);
                    chk("wr_data", wr_data, mon_e.data);
                end
            end
            if (done) begin
                done_cnt++;
                chk("done_with_hold", {31'd0, cpu_hold}, 32'd1);
            end
            if (prev_done) begin
                chk("done_one_cycle", {31'd0, done}, 32'd0);
                chk("hold_after_done", {31'd0, cpu_hold}, 32'd0);
            end
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    task automatic push_byte(input logic [7:0] v, input bit pulse_start);
        byte_valid = 1'b1;
        byte_data  = v;
        if (pulse_start) begin
            start     = 1'b1;
            len_words = 8'd3;
        end
        chk("ready_in_load", {31'd0, byte_ready}, 32'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic do_load(input int len, input int gap, input logic [7:0] bytes_in[$],
                           input int mid_start, input bit bad_trailer);
        logic [7:0] b[$];
        wr_t        e;
        int         d0;
`ifdef LOADER_CHECKSUM_EN
        logic [7:0] x;
        x = 8'd0;
`endif
        b = bytes_in;
        while (b.size() < len * 4) b.push_back(8'($urandom));
        for (int w = 0; w < len; w++) begin
            e.addr = 32'(w * 4);
            e.data = {b[4*w+3], b[4*w+2], b[4*w+1], b[4*w]};
            exp_q.push_back(e);
        end
        start     = 1'b1;
        len_words = 8'(len);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("start_clears_error", {31'd0, error}, 32'd0);
        chk("hold_in_load", {31'd0, cpu_hold}, 32'd1);
        d0 = done_cnt;
        for (int i = 0; i < len * 4; i++) begin
`ifdef LOADER_CHECKSUM_EN
            x ^= b[i];
`endif
            push_byte(b[i], i == mid_start);
            if (gap == 1 || (gap == 2 && $urandom_range(0, 2) == 0)) begin
                byte_valid = 1'b0;
                byte_data  = 8'($urandom);
                if (i != len * 4 - 1) chk("ready_in_gap", {31'd0, byte_ready}, 32'd1);
                @(posedge clk);
                #1;
            end
        end
`ifdef LOADER_CHECKSUM_EN
        push_byte(bad_trailer ? (x ^ 8'h01) : x, 1'b0);
`endif
        byte_valid = 1'b0;
        if (!bad_trailer) begin
            for (int i = 0; i < 20 && done_cnt == d0; i++) @(negedge clk);
            chk("done_count", 32'(done_cnt - d0), 32'd1);
            chk("queue_drained", 32'(exp_q.size()), 32'd0);
            chk("error_clear", {31'd0, error}, 32'd0);
            @(posedge clk);
            #1;
            chk("idle_no_hold", {31'd0, cpu_hold}, 32'd0);
            chk("idle_not_ready", {31'd0, byte_ready}, 32'd0);
        end else begin
            repeat (5) @(posedge clk);
            #1;
            chk("bad_no_done", 32'(done_cnt - d0), 32'd0);
            chk("bad_error", {31'd0, error}, 32'd1);
            chk("bad_hold", {31'd0, cpu_hold}, 32'd1);
            chk("bad_not_ready", {31'd0, byte_ready}, 32'd0);
            chk("bad_queue_drained", 32'(exp_q.size()), 32'd0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, {31'd0, byte_ready}, 32'd0);
        chk({tag, "_wr_en"}, {31'd0, wr_en}, 32'd0);
        chk({tag, "_wr_addr"}, wr_addr, 32'd0);
        chk({tag, "_wr_data"}, wr_data, 32'd0);
        chk({tag, "_hold"}, {31'd0, cpu_hold}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_error"}, {31'd0, error}, 32'd0);
    endtask

    task automatic bad_start(input logic [7:0] len, input string tag);
        int w0;
        w0 = wr_cnt;
        start     = 1'b1;
        len_words = len;
        @(posedge clk);
        #1;
        start      = 1'b0;
        byte_valid = 1'b1;
        byte_data  = 8'hA5;
        chk({tag, "_error"}, {31'd0, error}, 32'd1);
        chk({tag, "_hold"}, {31'd0, cpu_hold}, 32'd0);
        chk({tag, "_ready"}, {31'd0, byte_ready}, 32'd0);
        repeat (6) @(posedge clk);
        #1;
        byte_valid = 1'b0;
        chk({tag, "_no_wr"}, 32'(wr_cnt - w0), 32'd0);
        chk({tag, "_still_error"}, {31'd0, error}, 32'd1);
    endtask

    logic [7:0]  none[$];
    logic [7:0]  tbl[$];
    logic [63:0] t1;
    logic [31:0] t6;
    int          w0;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Known program words 0xE3A00013, 0xE1A01001
        t1 = 64'hE1A01001_E3A00013;
        tbl.delete();
        for (int i = 0; i < 8; i++) tbl.push_back(t1[8*i +: 8]);
        do_load(2, 0, tbl, -1, 1'b0);

        do_load(1, 1, none, -1, 1'b0);

        bad_start(8'd0, "len0");
        bad_start(8'd201, "len201");
        do_load(1, 0, none, -1, 1'b0);

        // Reset after two of four bytes
        start     = 1'b1;
        len_words = 8'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        push_byte(8'h5A, 1'b0);
        push_byte(8'hC3, 1'b0);
        byte_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("midreset");
        rst = 1'b1;
        do_load(1, 0, none, -1, 1'b0);

        w0 = wr_cnt;
        do_load(200, 0, none, 400, 1'b0);
        chk("full_wr_count", 32'(wr_cnt - w0), 32'd200);
        chk("full_last_addr", last_addr, 32'h31C);

        for (int k = 0; k < 8; k++) do_load($urandom_range(1, 6), 2, none, -1, 1'b0);

`ifdef LOADER_CHECKSUM_EN
        t6 = 32'h08040201;
        tbl.delete();
        for (int i = 0; i < 4; i++) tbl.push_back(t6[8*i +: 8]);
        do_load(1, 0, tbl, -1, 1'b0);
        do_load(1, 0, tbl, -1, 1'b1);
        do_load(2, 2, none, -1, 1'b0);
`else
        t6 = 32'd0;
        tbl.delete();
        tbl.push_back(t6[7:0]);
`endif

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
